// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the buffered serial transmitter:
//   - uart_state_e : transmitter FSM states (IDLE, START, DATA, PARITY, STOP)
//   - PAR_NONE / PAR_EVEN / PAR_ODD : parity mode selectors
//   - START_BIT / STOP_BIT : serial line levels of the framing bits
//   - calcParity : turns the XOR of a word into the transmitted parity bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Even parity transmits the XOR of the word so the total count of ones
    // is even; odd parity transmits its inverse. With no parity the bit is
    // never shifted out, so its value does not matter.
    function automatic logic calcParity(input logic xorAll, input int mode);
        logic result;
        result = 1'b0;
        if (mode == PAR_EVEN) begin
            result = xorAll;
        end else if (mode == PAR_ODD) begin
            result = ~xorAll;
        end else if (mode == PAR_NONE) begin
            result = 1'b0;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock FIFO with show-ahead output that buffers words for the
// transmitter.
// Parameters: WIDTH (word width), DEPTH (entries, power of 2, >= 2)
// Ports:
//   clk   in          : clock, rising edge
//   reset in          : asynchronous active-high reset, empties the FIFO
//   wr    in          : push din (accepted when not full, or when full and rd)
//   rd    in          : pop the head (ignored when empty)
//   din   in  [WIDTH] : word to push
//   dout  out [WIDTH] : head word, valid whenever empty is low
//   full  out         : registered, FIFO holds DEPTH words
//   empty out         : registered, FIFO holds no words
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             push;
    logic             pop;

    // A pop frees a slot on the same edge, so a full FIFO may still accept a
    // push when it is being read; that keeps the count at DEPTH and the new
    // word lands in the slot the head just vacated.
    always_comb begin
        pop     = rd && !empty_q;
        push    = wr && (!full_q || pop);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two. The flags are
    // registered from the next count so they describe the FIFO after the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == COUNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= din;
        end
    end

    assign dout  = mem[rptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffered asynchronous serial transmitter. Words written by the game
// controller are queued in a FIFO and shifted out LSB-first as frames of
// start bit, DATA_BITS data bits, optional parity bit and 1 or 2 stop bits.
// Parameters: CLKS_PER_BIT (>= 2), DATA_BITS (5..16), PARITY_MODE
//   (PAR_NONE/PAR_EVEN/PAR_ODD), STOP_BITS (1 or 2), FIFO_DEPTH (power of 2)
// Ports:
//   clk        in              : clock, rising edge
//   reset      in              : asynchronous active-high reset
//   i_data     in  [DATA_BITS] : word to queue, sampled when wr is high
//   wr         in              : push strobe, one word per cycle
//   o_full     out             : FIFO holds FIFO_DEPTH words
//   o_empty    out             : FIFO holds no words
//   o_busy     out             : a frame is on the line
//   o_overflow out             : one-cycle pulse after a dropped write
//   s_out      out             : registered serial line, idles high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 wr,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic                 s_out
);

    localparam int STOP_CYCLES = STOP_BITS * CLKS_PER_BIT;
    localparam int TW          = $clog2(STOP_CYCLES);
    localparam int BW          = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CYCLES - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
    localparam logic          HAS_PARITY = (PARITY_MODE != PAR_NONE);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [TW-1:0]        timer_q;
    logic [TW-1:0]        timer_d;
    logic [BW-1:0]        bitIdx_q;
    logic [BW-1:0]        bitIdx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 parity_q;
    logic                 parity_d;
    logic                 sOut_q;
    logic                 sOut_d;
    logic                 busy_q;
    logic                 overflow_q;
    logic                 load;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [DATA_BITS-1:0] fifoDout;

    uart_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .wr   (wr),
        .rd   (load),
        .din  (i_data),
        .dout (fifoDout),
        .full (fifoFull),
        .empty(fifoEmpty)
    );

    // Next-state logic. The timer counts cycles within the current bit (or
    // within the whole stop period) and restarts at every boundary. A word is
    // loaded either from IDLE or on the very last stop cycle, which lets
    // queued frames follow each other with no idle gap. Parity is computed
    // from the head word at load time and travels alongside the shift
    // register, since the shift register is destroyed while sending.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                load = !fifoEmpty;
            end
            START: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bitIdx_q == IDX_LAST) begin
                        bitIdx_d = '0;
                        if (HAS_PARITY) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PARITY: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == STOP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                    load    = !fifoEmpty;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            state_d  = START;
            timer_d  = '0;
            bitIdx_d = '0;
            shift_d  = fifoDout;
            parity_d = calcParity(^fifoDout, PARITY_MODE);
        end
    end

    // The line level is derived from the state being entered, so the
    // registered output changes on exactly the same edge as the state and
    // never glitches.
    always_comb begin
        sOut_d = STOP_BIT;
        case (state_d)
            IDLE:    sOut_d = STOP_BIT;
            START:   sOut_d = START_BIT;
            DATA:    sOut_d = shift_d[0];
            PARITY:  sOut_d = parity_d;
            STOP:    sOut_d = STOP_BIT;
            default: sOut_d = STOP_BIT;
        endcase
    end

    // State, datapath and output registers. Reset forces the line high at
    // once, abandoning any frame in flight. An overflow is flagged when a
    // write hits a full FIFO that is not being read on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            sOut_q     <= STOP_BIT;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            sOut_q     <= sOut_d;
            busy_q     <= (state_d != IDLE);
            overflow_q <= wr && fifoFull && !load;
        end
    end

    assign s_out      = sOut_q;
    assign o_busy     = busy_q;
    assign o_overflow = overflow_q;
    assign o_full     = fifoFull;
    assign o_empty    = fifoEmpty;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised serial transmitter with an input FIFO. It buffers parallel words written by the game controller and shifts each out LSB-first on `s_out` as an asynchronous serial frame: start bit, DATA_BITS data bits, optional parity bit, then 1 or 2 stop bits. It sits between the game logic and the serial link pin, and adds configurable width, parity and stop bits, buffering, flow-control flags and a reset.

## Interface
- `CLKS_PER_BIT`, 5: clock cycles per serial bit (48 kHz / 9600 baud); must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, 5..16.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: words buffered; a power of 2, ≥ 2.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_data` in DATA_BITS: word to transmit; sampled only on a `wr` cycle.
- `wr` in 1: write strobe; one word is pushed per cycle while high.
- `o_full` out 1: FIFO holds FIFO_DEPTH words.
- `o_empty` out 1: FIFO holds no words.
- `o_busy` out 1: a frame is being shifted (state ≠ IDLE).
- `o_overflow` out 1: one-cycle pulse when a write is dropped.
- `s_out` out 1: serial line; idles high.

## Operation
- Reset values (applied asynchronously): `s_out`=1, `o_busy`=0, `o_full`=0, `o_empty`=1, `o_overflow`=0. FIFO pointers and count clear to 0, state goes to IDLE, and the bit counters clear to 0.
- FIFO push: `wr`=1 and not full stores `i_data`. `wr`=1 while full drops the word and pulses `o_overflow` on the next cycle.
- Simultaneous push and pop while full: both succeed and the count is unchanged. Simultaneous push and pop while empty cannot occur, because a pop requires a non-empty FIFO.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE or START.
  - IDLE: `s_out`=1. If the FIFO is not empty, pop the head into the shift register and go to START.
  - START: `s_out`=0 for CLKS_PER_BIT cycles.
  - DATA: `s_out` = shift[0]. Shift right every CLKS_PER_BIT cycles, DATA_BITS times.
  - PARITY: entered only if PARITY_MODE≠0. `s_out` = XOR of the word (even mode) or its inverse (odd mode), held CLKS_PER_BIT cycles.
  - STOP: `s_out`=1 for STOP_BITS×CLKS_PER_BIT cycles. At the last cycle, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Parity is computed from the popped word at pop time and registered with it.
- Bit timer and bit index wrap to 0 at each bit or state boundary. The bit index is $clog2(DATA_BITS) wide.
- Unlike the previous generation, `wr` is a push strobe, not a transmit enable. Dropping `wr` never aborts a frame in flight.
- `reset` asserted mid-frame: the line returns to 1 immediately and the frame is truncated. Buffered words are discarded.

## Timing
- Each serial bit is exactly CLKS_PER_BIT cycles wide.
- Frame length is (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Latency, idle and empty case: `wr` sampled at edge k → word in FIFO after k. IDLE pops at k+1, and `s_out` goes low after edge k+1 (start bit begins one cycle after the write).
- `o_full` and `o_empty` are registered and reflect the count after each edge.
- `o_busy` rises with the START entry and falls on the STOP→IDLE edge.
- `s_out` is registered and glitch-free.

## Structure
- A shared package `uart_pkg` holds the state encoding (IDLE, START, DATA, PARITY, STOP), the parity-mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2) and the START_BIT=0 / STOP_BIT=1 constants.
- One sub-module, `uart_sync_fifo`: parameters WIDTH and DEPTH; ports clk, reset, wr, rd, din, dout, full, empty. dout is show-ahead (head valid whenever not empty).
- The top level holds the FSM, the bit timer, the shift register and the parity register.

## Test plan
- CLKS_PER_BIT=5, DATA_BITS=8, even parity, 1 stop bit; write 0xA5 while idle → `s_out` sequence 0,1,0,1,0,0,1,0,1,0,1, each level held 5 cycles. Total 55 cycles; start bit begins 1 cycle after `wr`.
- Odd parity, write 0xA5 → parity bit 1. PARITY_MODE=0 with STOP_BITS=2 → 11-bit frame with no parity bit and 10 high cycles of stop.
- FIFO_DEPTH=4; burst of 6 writes (0x01..0x06) on consecutive cycles while idle. The first write is popped at once, so four more fill the FIFO → `o_full` after the fifth write and one `o_overflow` pulse on the sixth. Frames 0x01..0x05 go out back-to-back with no idle cycle between the stop and the next start; 0x06 is never sent.
- Full FIFO with push and pop on the same edge → count stays 4, the new word is kept, and `o_overflow` stays 0.
- DATA_BITS=16, write 0x8001 → bit 0 and bit 15 are high, the 14 bits between them are low, and the frame is 18 bits long (no parity).
- Assert `reset` mid-DATA with 2 words queued → `s_out`=1 in the same cycle, `o_empty`=1 and `o_busy`=0. After release, a new write is transmitted correctly.
